// File: rtl/ransac_pkg.sv
// Shared definitions for the RANSAC point loader: CSR map, STATUS/CTRL bit
// positions and the loader FSM state type.
package ransac_pkg;

    localparam logic [2:0] CSR_CTRL     = 3'd0;
    localparam logic [2:0] CSR_BASE     = 3'd1;
    localparam logic [2:0] CSR_LENGTH   = 3'd2;
    localparam logic [2:0] CSR_STATUS   = 3'd3;
    localparam logic [2:0] CSR_COUNT    = 3'd4;
    localparam logic [2:0] CSR_CHECKSUM = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ABORTED  = 2;
    localparam int STAT_EOP_SEEN = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} loader_state_t;

endpackage

// File: rtl/ransac_point_loader_if.sv
// Bus bundle of the point loader: Avalon-ST point sink, Avalon-MM memory
// write master, CSR slave and IRQ. slave = loader view, master = system view.
interface ransac_point_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [DATA_W-1:0] st_data;
    logic              st_eop;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;

    logic [2:0]        csr_address;
    logic              csr_chipselect;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;

    logic              irq;

    modport slave (
        input  st_valid, st_data, st_eop,
        output st_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        input  csr_address, csr_chipselect, csr_read, csr_write, csr_writedata,
        output csr_readdata,
        output irq
    );

    modport master (
        output st_valid, st_data, st_eop,
        input  st_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        output csr_address, csr_chipselect, csr_read, csr_write, csr_writedata,
        input  csr_readdata,
        input  irq
    );

endinterface

// File: rtl/ransac_loader_csr.sv
// CSR register file of the point loader: BASE/LENGTH/CTRL storage, W1P/W1C
// decoding, sticky status flags, registered read data and level IRQ.
module ransac_loader_csr
    import ransac_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W:0]   length,
    output logic              start,
    output logic              abort,
    input  logic              busy,
    input  logic              run_clear,
    input  logic              done_set,
    input  logic              aborted_set,
    input  logic              eop_set,
    input  logic [ADDR_W:0]   count,
    input  logic [31:0]       checksum
);

    logic        wr, rd;
    logic        irq_en, done, aborted, eop_seen;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign wr    = csr_chipselect & csr_write;
    assign rd    = csr_chipselect & csr_read;
    assign start = wr && csr_address == CSR_CTRL && csr_writedata[CTRL_START];
    assign abort = wr && csr_address == CSR_CTRL && csr_writedata[CTRL_ABORT];
    assign irq   = done & irq_en;
    assign unused_wdata = ^csr_writedata[31:ADDR_W+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base     <= '0;
            length   <= '0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            eop_seen <= 1'b0;
        end else begin
            if (wr && csr_address == CSR_CTRL)
                irq_en <= csr_writedata[CTRL_IRQ_EN];
            if (wr && !busy && csr_address == CSR_BASE)
                base <= csr_writedata[ADDR_W-1:0];
            if (wr && !busy && csr_address == CSR_LENGTH)
                length <= csr_writedata[ADDR_W:0];

            // Hardware set outranks both the start clear and a software W1C.
            if (done_set)
                done <= 1'b1;
            else if (run_clear || (wr && csr_address == CSR_STATUS && csr_writedata[STAT_DONE]))
                done <= 1'b0;

            if (aborted_set)
                aborted <= 1'b1;
            else if (run_clear || (wr && csr_address == CSR_STATUS && csr_writedata[STAT_ABORTED]))
                aborted <= 1'b0;

            if (eop_set)
                eop_seen <= 1'b1;
            else if (run_clear)
                eop_seen <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_CTRL:     rd_mux[CTRL_IRQ_EN] = irq_en;
            CSR_BASE:     rd_mux = 32'(base);
            CSR_LENGTH:   rd_mux = 32'(length);
            CSR_STATUS: begin
                rd_mux[STAT_BUSY]     = busy;
                rd_mux[STAT_DONE]     = done;
                rd_mux[STAT_ABORTED]  = aborted;
                rd_mux[STAT_EOP_SEEN] = eop_seen;
            end
            CSR_COUNT:    rd_mux = 32'(count);
            CSR_CHECKSUM: rd_mux = checksum;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csr_readdata <= '0;
        else if (rd)
            csr_readdata <= rd_mux;
    end

endmodule

// File: rtl/ransac_point_loader.sv
// Streams Avalon-ST point words into the point memory via single-cycle writes.
// Optional running checksum at CSR 5 when RANSAC_LOADER_CHECKSUM_EN is defined.
module ransac_point_loader
    import ransac_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384
) (
    input  logic                  clk,
    input  logic                  reset,
    ransac_point_loader_if.slave  bus
);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] ptr, base;
    logic [ADDR_W:0]   count, count_inc, length;
    logic              start, abort, accept, last_beat;
    logic              run_clear, done_set, aborted_set, eop_set, abort_latched;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [31:0]       checksum;

    assign bus.st_ready       = (state == RUN);
    assign accept             = bus.st_valid & (state == RUN);
    assign count_inc          = count + 1'b1;
    assign last_beat          = accept & (bus.st_eop | (count_inc == length));
    assign run_clear          = start & (state == IDLE);
    assign aborted_set        = abort & (state == RUN);
    assign eop_set            = accept & bus.st_eop;
    // An aborted run leaves DRAIN without reporting done.
    assign done_set           = (run_clear & (length == '0)) | ((state == DRAIN) & ~abort_latched);

    assign bus.mem_write      = wr_valid;
    assign bus.mem_chipselect = wr_valid;
    assign bus.mem_byteenable = wr_valid ? 4'hF : 4'h0;
    assign bus.mem_address    = wr_addr;
    assign bus.mem_writedata  = wr_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && length != '0) state_next = RUN;
            RUN:     if (last_beat || abort)    state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            count         <= '0;
            abort_latched <= 1'b0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            state    <= state_next;
            wr_valid <= accept;
            if (accept) begin
                wr_addr <= ptr;
                wr_data <= bus.st_data;
                ptr     <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                count   <= count_inc;
            end
            if (run_clear) begin
                ptr           <= base;
                count         <= '0;
                abort_latched <= 1'b0;
            end
            if (aborted_set)
                abort_latched <= 1'b1;
        end
    end

`ifdef RANSAC_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            checksum <= '0;
        else if (run_clear)
            checksum <= '0;
        else if (wr_valid)
            checksum <= checksum + 32'(wr_data);
    end
`else
    assign checksum = '0;
`endif

    ransac_loader_csr #(.ADDR_W(ADDR_W)) u_csr (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (bus.csr_address),
        .csr_chipselect (bus.csr_chipselect),
        .csr_read       (bus.csr_read),
        .csr_write      (bus.csr_write),
        .csr_writedata  (bus.csr_writedata),
        .csr_readdata   (bus.csr_readdata),
        .irq            (bus.irq),
        .base           (base),
        .length         (length),
        .start          (start),
        .abort          (abort),
        .busy           (state != IDLE),
        .run_clear      (run_clear),
        .done_set       (done_set),
        .aborted_set    (aborted_set),
        .eop_set        (eop_set),
        .count          (count),
        .checksum       (checksum)
    );

endmodule

// File: tb/tb_ransac_point_loader.sv
// Scoreboard bench for ransac_point_loader: stimulus pushes expected memory
// writes and CSR read values; a negedge monitor pops and compares them.
module tb_ransac_point_loader;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    string       rd_name[$];
    logic        rd_issue = 1'b0;
    wr_t         e;
    string       n;

    ransac_point_loader_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    ransac_point_loader #(.ADDR_W(14), .DATA_W(32), .DEPTH(16384)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_issue <= bus.csr_read & bus.csr_chipselect;

    always @(negedge clk) begin
        if (bus.mem_write === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", {18'h0, bus.mem_address}, 32'hFFFF_FFFF);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", {18'h0, bus.mem_address}, {18'h0, e.a});
                chk("wr_data", bus.mem_writedata, e.d);
                chk("wr_be_cs", {27'h0, bus.mem_byteenable, bus.mem_chipselect}, 32'h1F);
            end
        end else begin
            if (bus.mem_chipselect !== 1'b0 || bus.mem_byteenable !== 4'h0)
                chk("idle_be_cs", {27'h0, bus.mem_byteenable, bus.mem_chipselect}, 32'h0);
        end
        if (rd_issue) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_read", bus.csr_readdata, 32'hDEAD_BEEF);
            end else begin
                n = rd_name.pop_front();
                chk(n, bus.csr_readdata, exp_rd.pop_front());
            end
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        bus.csr_address = a; bus.csr_writedata = d;
        bus.csr_chipselect = 1'b1; bus.csr_write = 1'b1;
        tick(1);
        bus.csr_chipselect = 1'b0; bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        bus.csr_address = a;
        bus.csr_chipselect = 1'b1; bus.csr_read = 1'b1;
        exp_rd.push_back(exp);
        rd_name.push_back(name);
        tick(1);
        bus.csr_chipselect = 1'b0; bus.csr_read = 1'b0;
    endtask

    // One beat presented for one clock; also raises abort in the same cycle if asked.
    task automatic beat(input logic [31:0] d, input logic eop, input logic [13:0] addr,
                        input logic with_abort);
        wr_t w;
        w.a = addr; w.d = d;
        exp_wr.push_back(w);
        bus.st_valid = 1'b1; bus.st_data = d; bus.st_eop = eop;
        if (with_abort) begin
            bus.csr_address = 3'd0; bus.csr_writedata = 32'h6;
            bus.csr_chipselect = 1'b1; bus.csr_write = 1'b1;
        end
        tick(1);
        bus.st_valid = 1'b0; bus.st_eop = 1'b0;
        bus.csr_chipselect = 1'b0; bus.csr_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bus.st_valid = 1'b0; bus.st_data = '0; bus.st_eop = 1'b0;
        bus.csr_address = '0; bus.csr_chipselect = 1'b0;
        bus.csr_read = 1'b0; bus.csr_write = 1'b0; bus.csr_writedata = '0;
        tick(3);
        reset = 1'b0;

        // Reset state
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);
        chk("rst_st_ready", {31'h0, bus.st_ready}, 32'h0);
        chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
        csr_rd(3'd3, 32'h0, "rst_status");
        csr_rd(3'd1, 32'h0, "rst_base");
        csr_rd(3'd2, 32'h0, "rst_length");
        csr_rd(3'd4, 32'h0, "rst_count");

        // st_valid in IDLE is not accepted
        bus.st_valid = 1'b1; bus.st_data = 32'h5555;
        tick(2);
        bus.st_valid = 1'b0;

        // Run 1: BASE=0x10, LENGTH=4, irq enabled
        csr_wr(3'd1, 32'h10);
        csr_wr(3'd2, 32'h4);
        csr_wr(3'd0, 32'h3);
        chk("s1_st_ready_run", {31'h0, bus.st_ready}, 32'h1);
        for (int i = 0; i < 4; i++)
            beat(32'hA0 + 32'(i), 1'b0, 14'h10 + 14'(i), 1'b0);
        chk("s1_st_ready_drain", {31'h0, bus.st_ready}, 32'h0);
        tick(2);
        csr_rd(3'd3, 32'h2, "s1_status");
        csr_rd(3'd4, 32'h4, "s1_count");
        chk("s1_irq", {31'h0, bus.irq}, 32'h1);
        chk("s1_pending_writes", exp_wr.size(), 32'h0);

        // Run 2: pointer wrap at the top of memory, irq disabled
        csr_wr(3'd1, 32'h3FFE);
        csr_wr(3'd0, 32'h1);
        beat(32'hB0, 1'b0, 14'h3FFE, 1'b0);
        beat(32'hB1, 1'b0, 14'h3FFF, 1'b0);
        beat(32'hB2, 1'b0, 14'h0000, 1'b0);
        beat(32'hB3, 1'b0, 14'h0001, 1'b0);
        tick(2);
        csr_rd(3'd3, 32'h2, "s2_status");
        chk("s2_irq_disabled", {31'h0, bus.irq}, 32'h0);
        chk("s2_pending_writes", exp_wr.size(), 32'h0);

        // Run 3: eop ends the set early; BASE write while busy is ignored
        csr_wr(3'd1, 32'h100);
        csr_wr(3'd2, 32'd100);
        csr_wr(3'd0, 32'h1);
        csr_wr(3'd1, 32'h777);
        beat(32'hC0, 1'b0, 14'h100, 1'b0);
        beat(32'hC1, 1'b0, 14'h101, 1'b0);
        beat(32'hC2, 1'b1, 14'h102, 1'b0);
        chk("s3_st_ready_after_eop", {31'h0, bus.st_ready}, 32'h0);
        tick(2);
        csr_rd(3'd3, 32'hA, "s3_status");
        csr_rd(3'd4, 32'h3, "s3_count");
        csr_rd(3'd1, 32'h100, "s3_base_frozen");
        chk("s3_pending_writes", exp_wr.size(), 32'h0);

        // Run 4: abort coinciding with the third beat
        csr_wr(3'd1, 32'h200);
        csr_wr(3'd2, 32'd10);
        csr_wr(3'd0, 32'h3);
        beat(32'hD0, 1'b0, 14'h200, 1'b0);
        beat(32'hD1, 1'b0, 14'h201, 1'b0);
        beat(32'hD2, 1'b0, 14'h202, 1'b1);
        tick(3);
        csr_rd(3'd3, 32'h4, "s4_status");
        csr_rd(3'd4, 32'h3, "s4_count");
        chk("s4_irq", {31'h0, bus.irq}, 32'h0);
        chk("s4_pending_writes", exp_wr.size(), 32'h0);

        // Run 5: LENGTH=0 start completes immediately; W1C of done
        csr_wr(3'd2, 32'h0);
        csr_wr(3'd0, 32'h3);
        csr_rd(3'd3, 32'h2, "s5_status_done");
        csr_rd(3'd4, 32'h0, "s5_count");
        chk("s5_irq", {31'h0, bus.irq}, 32'h1);
        csr_wr(3'd3, 32'h2);
        csr_rd(3'd3, 32'h0, "s5_status_cleared");
        chk("s5_irq_cleared", {31'h0, bus.irq}, 32'h0);
        tick(2);
        chk("s5_pending_writes", exp_wr.size(), 32'h0);

        // Run 6: checksum of 1, 2, 0xFFFFFFFF
        csr_wr(3'd1, 32'h0);
        csr_wr(3'd2, 32'h3);
        csr_wr(3'd0, 32'h1);
        beat(32'h1, 1'b0, 14'h0, 1'b0);
        beat(32'h2, 1'b0, 14'h1, 1'b0);
        beat(32'hFFFF_FFFF, 1'b0, 14'h2, 1'b0);
        tick(2);
`ifdef RANSAC_LOADER_CHECKSUM_EN
        csr_rd(3'd5, 32'h2, "s6_checksum");
`else
        csr_rd(3'd5, 32'h0, "s6_checksum");
`endif
        csr_rd(3'd6, 32'h0, "s6_unmapped");
        csr_rd(3'd0, 32'h0, "s6_ctrl");
        tick(2);
        chk("s6_pending_writes", exp_wr.size(), 32'h0);
        chk("pending_reads", exp_rd.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
